// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game-flow controller.
package pong_pkg;

    localparam int unsigned SCORE_W         = 4;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned WIN_SCORE_DEF   = 9;
    localparam int unsigned SERVE_DELAY_DEF = 120;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        SERVE = 2'd2,
        OVER  = 2'd3
    } state_t;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Saturating frame counter for the post-point serve hold; done once SERVE_DELAY ticks are seen.
module pong_serve_timer
    import pong_pkg::*;
#(
    parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SERVE_DELAY);

    logic [CNT_W-1:0] count;

    // done tracks count == LIMIT so it is valid the cycle after the last tick
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (tick && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
            done  <= ((count + CNT_W'(1)) == LIMIT);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: scoring, serve hold, win detection and button-gated restart.
// PONG_AUTO_SERVE_EN: serve resumes automatically once the delay expires (else needs a press).
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
    parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic [3:0]         btn,
    input  logic               miss_1,
    input  logic               miss_2,
    output logic               game,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               game_over,
    output logic               winner,
    output logic [1:0]         state
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t             st;
    logic               btn_any_q;
    logic               press_block;
    logic               press;
    logic               serve_clear;
    logic               serve_done;
    logic               serve_go;
    logic [SCORE_W-1:0] s1_inc;
    logic [SCORE_W-1:0] s2_inc;

    // press_block suppresses the event from a button still held when reset releases
    assign press       = (|btn) & ~btn_any_q & ~press_block;
    assign serve_clear = (st != SERVE);
    assign s1_inc      = score_inc(score_1);
    assign s2_inc      = score_inc(score_2);
    assign state       = st;

`ifdef PONG_AUTO_SERVE_EN
    assign serve_go = serve_done;
`else
    assign serve_go = serve_done & press;
`endif

    pong_serve_timer #(
        .SERVE_DELAY (SERVE_DELAY)
    ) u_serve_timer (
        .clk   (clk),
        .reset (reset),
        .clear (serve_clear),
        .tick  (refresh_tick),
        .done  (serve_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= IDLE;
            game        <= 1'b1;
            score_1     <= '0;
            score_2     <= '0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            btn_any_q   <= 1'b0;
            press_block <= |btn;
        end else begin
            btn_any_q <= |btn;
            if (!(|btn)) begin
                press_block <= 1'b0;
            end
            case (st)
                IDLE: begin
                    if (press) begin
                        st   <= PLAY;
                        game <= 1'b0;
                    end
                end
                PLAY: begin
                    // leaving PLAY on the first miss cycle makes a long miss score once
                    if (miss_1) begin
                        score_1 <= s1_inc;
                        game    <= 1'b1;
                        if (s1_inc == WIN) begin
                            st        <= OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            st <= SERVE;
                        end
                    end else if (miss_2) begin
                        score_2 <= s2_inc;
                        game    <= 1'b1;
                        if (s2_inc == WIN) begin
                            st        <= OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            st <= SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (serve_go) begin
                        st   <= PLAY;
                        game <= 1'b0;
                    end
                end
                OVER: begin
                    if (press) begin
                        st        <= IDLE;
                        score_1   <= '0;
                        score_2   <= '0;
                        winner    <= 1'b0;
                        game_over <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: vector table, directed corner sequences, randomized run vs. a rules model.
module tb_pong_game_ctrl;

    localparam int W = 9;
    localparam int D = 120;

    logic       clk = 1'b0;
    logic       reset, refresh_tick, miss_1, miss_2;
    logic [3:0] btn;
    logic       game, game_over, winner;
    logic [3:0] score_1, score_2;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // rules model: phase 0 idle, 1 play, 2 serve, 3 over
    int m_phase, m_s1, m_s2, m_over, m_win, m_ticks, m_prev_any, m_block;

    pong_game_ctrl #(.WIN_SCORE(W), .SERVE_DELAY(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .btn          (btn),
        .miss_1       (miss_1),
        .miss_2       (miss_2),
        .game         (game),
        .score_1      (score_1),
        .score_2      (score_2),
        .game_over    (game_over),
        .winner       (winner),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic t, input logic [3:0] b,
                              input logic m1, input logic m2);
        int any, prs, old_phase, ready;
        any = (b != 4'd0) ? 1 : 0;
        if (r) begin
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0;
            m_ticks = 0; m_prev_any = 0; m_block = any;
            return;
        end
        prs = (any == 1 && m_prev_any == 0 && m_block == 0) ? 1 : 0;
        m_prev_any = any;
        if (any == 0) m_block = 0;
        old_phase = m_phase;
        ready = (m_ticks == D) ? 1 : 0;
        case (m_phase)
            0: if (prs == 1) m_phase = 1;
            1: begin
                if (m1) begin
                    m_s1++;
                    if (m_s1 == W) begin m_phase = 3; m_over = 1; m_win = 0; end
                    else m_phase = 2;
                end else if (m2) begin
                    m_s2++;
                    if (m_s2 == W) begin m_phase = 3; m_over = 1; m_win = 1; end
                    else m_phase = 2;
                end
            end
            2: begin
`ifdef PONG_AUTO_SERVE_EN
                if (ready == 1) m_phase = 1;
`else
                if (ready == 1 && prs == 1) m_phase = 1;
`endif
            end
            default: if (prs == 1) begin
                m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_over = 0;
            end
        endcase
        if (old_phase == 2) begin
            if (t && m_ticks < D) m_ticks++;
        end else begin
            m_ticks = 0;
        end
    endtask

    task automatic step(input logic r, input logic t, input logic [3:0] b,
                        input logic m1, input logic m2);
        @(negedge clk);
        reset = r; refresh_tick = t; btn = b; miss_1 = m1; miss_2 = m2;
        @(posedge clk);
        model_step(r, t, b, m1, m2);
        #1;
    endtask

    task automatic serve_out();
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifndef PONG_AUTO_SERVE_EN
        step(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`endif
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] b;
        logic       m1;
        logic       m2;
        int         st;
        int         g;
        int         s1;
        int         s2;
        int         ov;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [3:0] rb;
        logic       rr, rt, rm1, rm2;
        int         exp_v, got_v;
        reset = 1'b1; refresh_tick = 1'b0; btn = 4'd0; miss_1 = 1'b0; miss_2 = 1'b0;

        vecs[0]  = '{1'b1, 4'd0,    1'b0, 1'b0, 0, 1, 0, 0, 0};
        vecs[1]  = '{1'b0, 4'd0,    1'b0, 1'b0, 0, 1, 0, 0, 0};
        vecs[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1, 0, 0, 0, 0};
        vecs[3]  = '{1'b0, 4'd0,    1'b0, 1'b0, 1, 0, 0, 0, 0};
        vecs[4]  = '{1'b0, 4'd0,    1'b1, 1'b0, 2, 1, 1, 0, 0};
        vecs[5]  = '{1'b0, 4'd0,    1'b1, 1'b0, 2, 1, 1, 0, 0};
        vecs[6]  = '{1'b0, 4'd0,    1'b1, 1'b0, 2, 1, 1, 0, 0};
        vecs[7]  = '{1'b0, 4'd0,    1'b1, 1'b1, 2, 1, 1, 0, 0};
        vecs[8]  = '{1'b0, 4'd0,    1'b1, 1'b0, 2, 1, 1, 0, 0};
        vecs[9]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 2, 1, 1, 0, 0};
        vecs[10] = '{1'b0, 4'd0,    1'b0, 1'b0, 2, 1, 1, 0, 0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, 1'b0, vecs[i].b, vecs[i].m1, vecs[i].m2);
            check($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            check($sformatf("vec%0d_game", i), int'(game), vecs[i].g);
            check($sformatf("vec%0d_s1", i), int'(score_1), vecs[i].s1);
            check($sformatf("vec%0d_s2", i), int'(score_2), vecs[i].s2);
            check($sformatf("vec%0d_over", i), int'(game_over), vecs[i].ov);
        end

        // serve delay: held for the full tick count
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
            if (i == D - 2) check("serve_hold_119", int'(state), 2);
        end
        check("serve_hold_120", int'(state), 2);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef PONG_AUTO_SERVE_EN
        check("auto_serve_exit", int'(state), 1);
        check("auto_serve_game", int'(game), 0);
`else
        check("manual_serve_wait", int'(state), 2);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        check("manual_serve_exit", int'(state), 1);
        check("manual_serve_game", int'(game), 0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`endif

        // simultaneous misses: player 1 wins the point
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("both_miss_s1", int'(score_1), 2);
        check("both_miss_s2", int'(score_2), 0);
        check("both_miss_state", int'(state), 2);
        serve_out();

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
            serve_out();
        end
        check("pre_win_s2", int'(score_2), 8);
        check("pre_win_state", int'(state), 1);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("win_s2", int'(score_2), 9);
        check("win_over", int'(game_over), 1);
        check("win_winner", int'(winner), 1);
        check("win_state", int'(state), 3);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("over_ignore_s1", int'(score_1), 2);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("over_ignore_s2", int'(score_2), 9);
        check("over_game", int'(game), 1);
        step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
        check("restart_state", int'(state), 0);
        check("restart_scores", int'({score_1, score_2}), 0);
        check("restart_over", int'(game_over), 0);
        check("restart_winner", int'(winner), 0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // reset in SERVE with a button held through it
        step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        check("pre_reset_state", int'(state), 2);
        step(1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
        check("reset_state", int'(state), 0);
        check("reset_s1", int'(score_1), 0);
        check("reset_game", int'(game), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        check("held_no_press", int'(state), 0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("released_idle", int'(state), 0);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        check("repress_play", int'(state), 1);

        // randomized run against the rules model
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        rb = 4'd0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 7) == 0) rb = 4'($urandom);
            rr  = ($urandom_range(0, 2999) == 0);
            rt  = 1'($urandom);
            rm1 = ($urandom_range(0, 15) == 0);
            rm2 = ($urandom_range(0, 15) == 0);
            step(rr, rt, rb, rm1, rm2);
            got_v = int'({state, game, score_1, score_2, game_over, game_over & winner});
            exp_v = (m_phase << 11) | (((m_phase != 1) ? 1 : 0) << 10) | (m_s1 << 6)
                  | (m_s2 << 2) | (m_over << 1) | (m_over & m_win);
            check("random_model", got_v, exp_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
